clk_freq_monitor: RTL

CLK_FREQ_MONITOR -- requirements
Module: clk_freq_monitor

---
 rtl/clk_mon_pkg.sv | 23 ++
 rtl/sync_edge_det.sv | 33 +++
 rtl/clk_freq_monitor.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/clk_mon_pkg.sv
// clk_mon_pkg
// Shared types and constants for the clock frequency monitor.
//   state_t     : monitor FSM states (IDLE, FILL, MEASURE)
//   CNT_W       : width of the edge counter and of the count output
//   FILL_CYCLES : cycles spent flushing the synchronizer before a window
//   gate_cnt_w  : width needed for a gate counter running 0..GATE_CYCLES-1
package clk_mon_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    MEASURE
  } state_t;

  localparam int CNT_W       = 16;
  localparam int FILL_CYCLES = 2;

  // Never returns 0 so a degenerate 1-cycle window still gets a legal vector.
  function automatic int gate_cnt_w(input int gate_cycles);
    return (gate_cycles > 1) ? $clog2(gate_cycles) : 1;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det
// Brings an asynchronous input into the clk domain through two flops and
// flags its rising edges with one further register.
//   clk   : sampling clock
//   rst_n : synchronous active-low reset, clears all three flops
//   d     : asynchronous input
//   rise  : high for one clk cycle per synchronized rising edge of d
module sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic sync1;
  logic sync2;
  logic prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= d;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign rise = sync2 & ~prev;

endmodule

// File: rtl/clk_freq_monitor.sv
// clk_freq_monitor
// Counts rising edges of mon_in over back-to-back windows of GATE_CYCLES clk
// cycles, compares each window against EXP_COUNT +/- TOL and qualifies the
// monitored clock after LOCK_WINDOWS consecutive good windows.
//   clk         : reference clock
//   rst_n       : synchronous active-low reset
//   en          : enables monitoring; dropping it discards the open window
//   mon_in      : monitored clock, asynchronous, below clk/2
//   fault_clr   : clears the latched fault (latched build only)
//   count       : edge count of the last completed window
//   count_valid : one-cycle pulse when count is loaded
//   in_range    : last window was within tolerance
//   locked      : LOCK_WINDOWS consecutive in-range windows seen
//   fault       : out-of-range window detected
// Build option CLK_MON_FAULT_LATCH_EN: when defined, fault is a sticky flag
// cleared by fault_clr (a new set wins over a clear); otherwise fault simply
// mirrors ~in_range once a window has completed since en rose.
module clk_freq_monitor
  import clk_mon_pkg::*;
#(
  parameter int GATE_CYCLES  = 27000,
  parameter int EXP_COUNT    = 4800,
  parameter int TOL          = 48,
  parameter int LOCK_WINDOWS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mon_in,
  input  logic             fault_clr,
  output logic [CNT_W-1:0] count,
  output logic             count_valid,
  output logic             in_range,
  output logic             locked,
  output logic             fault
);

  localparam int GW = gate_cnt_w(GATE_CYCLES);
  localparam int SW = $clog2(LOCK_WINDOWS + 1);

  localparam logic [GW-1:0]           GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [SW-1:0]           LOCK_N    = SW'(LOCK_WINDOWS);
  localparam logic signed [CNT_W:0]   EXP_S     = (CNT_W + 1)'(EXP_COUNT);
  localparam logic signed [CNT_W:0]   TOL_S     = (CNT_W + 1)'(TOL);

  state_t             state_q;
  state_t             state_d;
  logic               fill_done;
  logic [GW-1:0]      gate_q;
  logic [CNT_W-1:0]   edge_q;
  logic [SW-1:0]      streak_q;
  logic               rise;
  logic               terminal;
  logic [CNT_W-1:0]   final_cnt;
  logic signed [CNT_W:0] dev;
  logic signed [CNT_W:0] abs_dev;
  logic               win_ok;
  logic [SW-1:0]      streak_next;

  sync_edge_det u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (mon_in),
    .rise  (rise)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FILL holds for FILL_CYCLES cycles; fill_done marks its last cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (en) state_d = FILL;
      FILL:    if (fill_done) state_d = MEASURE;
      MEASURE: state_d = MEASURE;
      default: state_d = IDLE;
    endcase
    if (!en) state_d = IDLE;
  end

  // An edge arriving in the terminal cycle is folded into final_cnt so it
  // lands in the closing window rather than the next one.
  always_comb begin
    terminal    = (state_q == MEASURE) && (gate_q == GATE_LAST);
    final_cnt   = (rise && (edge_q != {CNT_W{1'b1}})) ? edge_q + 1'b1 : edge_q;
    dev         = $signed({1'b0, final_cnt}) - EXP_S;
    abs_dev     = dev[CNT_W] ? -dev : dev;
    win_ok      = (abs_dev <= TOL_S);
    streak_next = (streak_q == LOCK_N) ? streak_q : streak_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fill_done   <= 1'b0;
      gate_q      <= '0;
      edge_q      <= '0;
      streak_q    <= '0;
      count       <= '0;
      count_valid <= 1'b0;
      in_range    <= 1'b0;
      locked      <= 1'b0;
    end else begin
      count_valid <= 1'b0;
      if (!en) begin
        fill_done <= 1'b0;
        gate_q    <= '0;
        edge_q    <= '0;
        streak_q  <= '0;
        in_range  <= 1'b0;
        locked    <= 1'b0;
      end else begin
        unique case (state_q)
          FILL: begin
            fill_done <= (FILL_CYCLES > 1) ? ~fill_done : 1'b0;
          end
          MEASURE: begin
            if (terminal) begin
              gate_q      <= '0;
              edge_q      <= '0;
              count       <= final_cnt;
              count_valid <= 1'b1;
              in_range    <= win_ok;
              if (win_ok) begin
                streak_q <= streak_next;
                locked   <= (streak_next == LOCK_N);
              end else begin
                streak_q <= '0;
                locked   <= 1'b0;
              end
            end else begin
              gate_q <= gate_q + 1'b1;
              edge_q <= final_cnt;
            end
          end
          default: begin
            fill_done <= 1'b0;
            gate_q    <= '0;
            edge_q    <= '0;
          end
        endcase
      end
    end
  end

`ifdef CLK_MON_FAULT_LATCH_EN
  logic fault_set;
  assign fault_set = en && terminal && !win_ok;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fault <= 1'b0;
    end else if (fault_set) begin
      fault <= 1'b1;
    end else if (fault_clr) begin
      fault <= 1'b0;
    end
  end
`else
  // done_q remembers that at least one window has closed since en rose.
  logic done_q;
  logic unused_fault_clr;
  assign unused_fault_clr = fault_clr;

  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      done_q <= 1'b0;
    end else if (terminal) begin
      done_q <= 1'b1;
    end
  end

  assign fault = ~in_range & done_q;
`endif

endmodule
